// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the CPU data port, the DMA master port and the
// single-ported data memory port that dmem_arbiter sits between.
//   modport slave  : the arbiter's view (requests in, grants/memory out)
//   modport master : the surrounding system's view (requests out, grants in)
// CPU : cpu_en/cpu_wr (byte enables/strobes), cpu_addr, cpu_wdata -> cpu_rdata, cpu_stall
// DMA : dma_req, dma_wr, dma_addr, dma_wdata, dma_lock -> dma_gnt, dma_rvalid, dma_rdata
// MEM : mem_en, mem_wr, mem_addr, mem_wdata -> memory ; mem_rdata <- memory (1-cycle latency)
interface dmem_arbiter_if;
  logic [3:0]  cpu_en;
  logic [3:0]  cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic [3:0]  dma_wr;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_lock;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;

  logic [3:0]  mem_en;
  logic [3:0]  mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_en, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_wr, dma_addr, dma_wdata, dma_lock,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_en, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_wr, dma_addr, dma_wdata, dma_lock,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the 1-cycle-latency data memory between the CPU data
// port (requester 0) and a DMA master (requester 1). One access per cycle,
// grant is combinational, read data is steered back to the issuing requester.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : dmem_arbiter_if.slave (CPU, DMA and memory signals)
// Parameters: MAX_WAIT (1..15) DMA losses before force-grant,
//             MAX_LOCK (1..15) consecutive DMA grants under dma_lock.
// Build option: define DMEM_ARB_STARVE_EN to compile in the DMA starvation
// bound (wait counter, force-grant) and the CPU_SLOT lock breaker. Without
// it the CPU has strict priority and a lock lasts until dma_req/dma_lock drop.
//
// state    | meaning
// CPU_PRI  | CPU has priority; DMA takes idle cycles (or forced when starved)
// DMA_LOCK | back-to-back DMA grants while dma_lock is held
// CPU_SLOT | one cycle reserved for the CPU after a full-length lock
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    CPU_PRI  = 2'd0,
    DMA_LOCK = 2'd1,
    CPU_SLOT = 2'd2
  } state_e;

  if (MAX_WAIT < 1 || MAX_WAIT > 15 || MAX_LOCK < 1 || MAX_LOCK > 15) begin : g_param_check
    $error("dmem_arbiter: MAX_WAIT and MAX_LOCK must be in 1..15");
  end

  state_e      state_q, state_d;
  logic [3:0]  lock_cnt_q, lock_cnt_d;
  logic        rd_pending_q, rd_pending_d;
  logic        rd_owner_q, rd_owner_d;   // 1: DMA issued the pending read
  logic        cpu_req;
  logic        cpu_gnt;
  logic        dma_gnt;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        force_gnt;
`endif

  always_comb begin
    cpu_req    = |bus.cpu_en;
    dma_gnt    = 1'b0;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
`ifdef DMEM_ARB_STARVE_EN
    force_gnt  = bus.dma_req && (wait_cnt_q == MAX_WAIT_C);
`endif
    case (state_q)
      CPU_PRI: begin
`ifdef DMEM_ARB_STARVE_EN
        dma_gnt = bus.dma_req && (!cpu_req || force_gnt);
`else
        dma_gnt = bus.dma_req && !cpu_req;
`endif
        if (dma_gnt && bus.dma_lock) begin
          state_d    = DMA_LOCK;
          lock_cnt_d = 4'd1;
`ifdef DMEM_ARB_STARVE_EN
          // A one-grant lock is already exhausted by the entry grant.
          if (MAX_LOCK_C == 4'd1) begin
            state_d    = CPU_SLOT;
            lock_cnt_d = 4'd0;
          end
`endif
        end
      end
      DMA_LOCK: begin
        if (bus.dma_req && bus.dma_lock) begin
`ifdef DMEM_ARB_STARVE_EN
          dma_gnt = (lock_cnt_q < MAX_LOCK_C);
          if (dma_gnt) lock_cnt_d = lock_cnt_q + 4'd1;
          // Leave as soon as the last allowed grant is issued so the CPU
          // slot follows immediately.
          if (lock_cnt_d >= MAX_LOCK_C) begin
            state_d    = CPU_SLOT;
            lock_cnt_d = 4'd0;
          end
`else
          dma_gnt = 1'b1;
          if (lock_cnt_q != 4'hF) lock_cnt_d = lock_cnt_q + 4'd1;
`endif
        end else begin
          state_d    = CPU_PRI;
          lock_cnt_d = 4'd0;
        end
      end
      CPU_SLOT: begin
        state_d    = CPU_PRI;
        lock_cnt_d = 4'd0;
      end
      default: begin
        state_d    = CPU_PRI;
        lock_cnt_d = 4'd0;
      end
    endcase

    cpu_gnt      = cpu_req && !dma_gnt;
    rd_pending_d = (dma_gnt && (bus.dma_wr == 4'd0)) || (cpu_gnt && (bus.cpu_wr == 4'd0));
    rd_owner_d   = dma_gnt;

`ifdef DMEM_ARB_STARVE_EN
    wait_cnt_d = wait_cnt_q;
    if (!bus.dma_req || dma_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (state_q == CPU_SLOT && bus.dma_lock) begin
      // The lock only yielded one slot; let it resume on the next cycle.
      wait_cnt_d = MAX_WAIT_C;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
`endif
  end

  always_comb begin
    bus.mem_en    = 4'd0;
    bus.mem_wr    = 4'd0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    if (dma_gnt) begin
      bus.mem_en    = 4'hF;
      bus.mem_wr    = bus.dma_wr;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end else if (cpu_gnt) begin
      bus.mem_en    = bus.cpu_en;
      bus.mem_wr    = bus.cpu_wr;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CPU_PRI;
      lock_cnt_q   <= 4'd0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
`ifdef DMEM_ARB_STARVE_EN
      wait_cnt_q   <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
`ifdef DMEM_ARB_STARVE_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_stall  = cpu_req && !cpu_gnt;
  assign bus.dma_rvalid = rd_pending_q && rd_owner_q;
  assign bus.dma_rdata  = (rd_pending_q && rd_owner_q)  ? bus.mem_rdata : 32'd0;
  assign bus.cpu_rdata  = (rd_pending_q && !rd_owner_q) ? bus.mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter. A small byte-enable memory
// model answers the arbiter; expected DMA read data is queued when a DMA read
// grant is expected and popped when dma_rvalid appears.
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int MAX_LOCK = 8;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  dmem_arbiter_if bus();

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:63];
  logic [31:0] mem_rdata_q;

  assign bus.mem_rdata = mem_rdata_q;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem[16] <= 32'hDEADBEEF;   // 0x40
      mem[17] <= 32'h11223344;   // 0x44
      mem[18] <= 32'h0BADF00D;   // 0x48
      mem[19] <= 32'hCAFEF00D;   // 0x4C
      mem[32] <= 32'hAABBCCDD;   // 0x80
      mem_rdata_q <= 32'd0;
    end else if (bus.mem_en != 4'd0) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wr[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      mem_rdata_q <= mem[bus.mem_addr[7:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.dma_rvalid === 1'b1) begin
      if (exp_q.size() == 0) check("dma_rvalid_unexpected", 32'(bus.dma_rvalid), 32'd0);
      else check("dma_rdata", bus.dma_rdata, exp_q.pop_front());
    end
  end

  task automatic idle_inputs();
    bus.cpu_en = 4'd0;  bus.cpu_wr = 4'd0;  bus.cpu_addr = 32'd0;  bus.cpu_wdata = 32'd0;
    bus.dma_req = 1'b0; bus.dma_wr = 4'd0;  bus.dma_addr = 32'd0;  bus.dma_wdata = 32'd0;
    bus.dma_lock = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_dma;
    logic prev_dma;
    int   n_cyc;

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    #3;
    check("rst_dma_gnt",    32'(bus.dma_gnt),    32'd0);
    check("rst_cpu_stall",  32'(bus.cpu_stall),  32'd0);
    check("rst_mem_en",     32'(bus.mem_en),     32'd0);
    check("rst_mem_wr",     32'(bus.mem_wr),     32'd0);
    check("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check("rst_cpu_rdata",  bus.cpu_rdata,       32'd0);
    check("rst_dma_rdata",  bus.dma_rdata,       32'd0);
    rst = 1'b0;

    // Idle CPU, DMA read of 0x40
    step();
    bus.dma_req = 1'b1; bus.dma_addr = 32'h40; bus.dma_wr = 4'd0;
    #3;
    check("t1_dma_gnt",   32'(bus.dma_gnt),   32'd1);
    check("t1_mem_en",    32'(bus.mem_en),    32'hF);
    check("t1_mem_wr",    32'(bus.mem_wr),    32'd0);
    check("t1_mem_addr",  bus.mem_addr,       32'h40);
    exp_q.push_back(32'hDEADBEEF);
    step();
    idle_inputs();
    #3;
    check("t1_dma_rvalid", 32'(bus.dma_rvalid), 32'd1);
    check("t1_cpu_stall",  32'(bus.cpu_stall),  32'd0);
    check("t1_cpu_rdata",  bus.cpu_rdata,       32'd0);

    // CPU read of 0x44
    step();
    bus.cpu_en = 4'hF; bus.cpu_addr = 32'h44;
    #3;
    check("t2_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    check("t2_dma_gnt",   32'(bus.dma_gnt),   32'd0);
    check("t2_mem_addr",  bus.mem_addr,       32'h44);
    step();
    idle_inputs();
    #3;
    check("t2_cpu_rdata",  bus.cpu_rdata,       32'h11223344);
    check("t2_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check("t2_dma_rdata",  bus.dma_rdata,       32'd0);
    step();
    #3;
    check("t2_cpu_rdata_idle", bus.cpu_rdata, 32'd0);

    // CPU reads every cycle with DMA read held: starvation bound
    step();
    bus.cpu_en = 4'hF; bus.cpu_addr = 32'h48;
    bus.dma_req = 1'b1; bus.dma_addr = 32'h4C;
    n_cyc = STARVE ? 2 * (MAX_WAIT + 1) : 100;
    prev_dma = 1'b0;
    for (int c = 1; c <= n_cyc; c++) begin
      if (c > 1) step();
      #3;
      exp_dma = STARVE && ((c % (MAX_WAIT + 1)) == 0);
      check("starve_dma_gnt",   32'(bus.dma_gnt),   32'(exp_dma));
      check("starve_cpu_stall", 32'(bus.cpu_stall), 32'(exp_dma));
      if (c > 1) check("starve_cpu_rdata", bus.cpu_rdata, prev_dma ? 32'd0 : 32'h0BADF00D);
      if (exp_dma) exp_q.push_back(32'hCAFEF00D);
      prev_dma = exp_dma;
    end
    step();
    idle_inputs();
    #3;
    check("starve_cpu_rdata_last", bus.cpu_rdata, prev_dma ? 32'd0 : 32'h0BADF00D);

    // dma_lock held while the CPU keeps requesting
    step();
    bus.dma_req = 1'b1; bus.dma_lock = 1'b1; bus.dma_addr = 32'h4C;
    #3;
    check("lock_entry_gnt", 32'(bus.dma_gnt), 32'd1);
    exp_q.push_back(32'hCAFEF00D);
    for (int c = 1; c <= 3 * (MAX_LOCK + 1) - 1; c++) begin
      step();
      if (c == 1) begin
        bus.cpu_en = 4'hF; bus.cpu_addr = 32'h48;
      end
      #3;
      exp_dma = !STARVE || ((c % (MAX_LOCK + 1)) != MAX_LOCK);
      check("lock_dma_gnt",   32'(bus.dma_gnt),   32'(exp_dma));
      check("lock_cpu_stall", 32'(bus.cpu_stall), 32'(exp_dma));
      check("lock_mem_addr",  bus.mem_addr,       exp_dma ? 32'h4C : 32'h48);
      if (exp_dma) exp_q.push_back(32'hCAFEF00D);
    end
    step();
    idle_inputs();
    #3;
    check("lock_exit_dma_gnt", 32'(bus.dma_gnt), 32'd0);

    // CPU partial write and DMA read of the same word in the same cycle
    step();
    bus.cpu_en = 4'b0011; bus.cpu_wr = 4'b0011; bus.cpu_addr = 32'h80; bus.cpu_wdata = 32'h12345678;
    bus.dma_req = 1'b1; bus.dma_addr = 32'h80; bus.dma_wr = 4'd0;
    #3;
    check("merge_dma_gnt",   32'(bus.dma_gnt),   32'd0);
    check("merge_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    check("merge_mem_wr",    32'(bus.mem_wr),    32'h3);
    check("merge_mem_wdata", bus.mem_wdata,      32'h12345678);
    step();
    bus.cpu_en = 4'd0; bus.cpu_wr = 4'd0;
    #3;
    check("merge_dma_gnt2",    32'(bus.dma_gnt),    32'd1);
    check("merge_no_wr_rvalid", 32'(bus.dma_rvalid), 32'd0);
    exp_q.push_back(32'hAABB5678);
    step();
    idle_inputs();
    #3;
    check("merge_dma_rvalid", 32'(bus.dma_rvalid), 32'd1);

    // Reset the cycle after a granted (locking) DMA read
    step();
    bus.dma_req = 1'b1; bus.dma_lock = 1'b1; bus.dma_addr = 32'h40;
    #3;
    check("rstmid_dma_gnt", 32'(bus.dma_gnt), 32'd1);
    step();
    idle_inputs();
    rst = 1'b1;
    #3;
    check("rstmid_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check("rstmid_dma_rdata",  bus.dma_rdata,       32'd0);
    check("rstmid_mem_en",     32'(bus.mem_en),     32'd0);
    check("rstmid_cpu_stall",  32'(bus.cpu_stall),  32'd0);
    step();
    #3;
    check("rstmid_dma_rvalid2", 32'(bus.dma_rvalid), 32'd0);
    rst = 1'b0;
    step();
    bus.cpu_en = 4'hF; bus.cpu_addr = 32'h44;
    bus.dma_req = 1'b1; bus.dma_lock = 1'b1; bus.dma_addr = 32'h40;
    #3;
    check("rstmid_cpu_pri_dma_gnt",   32'(bus.dma_gnt),   32'd0);
    check("rstmid_cpu_pri_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    step();
    idle_inputs();
    #3;
    check("rstmid_cpu_rdata",   bus.cpu_rdata,       32'h11223344);
    check("rstmid_dma_rvalid3", 32'(bus.dma_rvalid), 32'd0);
    step();
    step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-ported, 1-cycle-latency data memory. The CPU pipeline's data port (requester 0) and an SPU/SPART DMA master (requester 1) share the memory through this block. The arbiter issues one access per cycle and routes read data back to the requester that issued it. It stalls the CPU pipeline on lost arbitration and bounds DMA starvation and DMA lock duration.

## Interface
- MAX_WAIT, 4: cycles a pending DMA request may lose before it is force-granted (range 1..15).
- MAX_LOCK, 8: maximum consecutive DMA grants under dma_lock (range 1..15).
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpu_en  input  4  CPU byte enables; nonzero means CPU request.
- cpu_wr  input  4  CPU byte write strobes (subset of cpu_en).
- cpu_addr  input  32  CPU byte address.
- cpu_wdata  input  32  CPU write data.
- cpu_rdata  output  32  read data, valid the cycle after a granted CPU read.
- cpu_stall  output  1  CPU request present and not granted this cycle.
- dma_req  input  1  DMA request.
- dma_wr  input  4  DMA byte write strobes; 0 means word read.
- dma_addr  input  32  DMA byte address.
- dma_wdata  input  32  DMA write data.
- dma_lock  input  1  request back-to-back DMA grants.
- dma_gnt  output  1  DMA access issued this cycle.
- dma_rvalid  output  1  dma_rdata valid (cycle after granted DMA read).
- dma_rdata  output  32  DMA read data.
- mem_en, mem_wr  output  4 each  byte enables and write strobes to the memory.
- mem_addr, mem_wdata  output  32 each  address and write data to the memory.
- mem_rdata  input  32  memory read data, 1 cycle after the access.

## Operation
- Grant is combinational from the inputs and the current state. Memory outputs mux the granted requester. With no grant, mem_en = 0 and mem_wr = 0.
- The DMA access uses mem_en = 4'hF and mem_wr = dma_wr.
- State machine:
  - CPU_PRI (reset state): CPU granted whenever cpu_en != 0. DMA is granted if dma_req and (cpu_en == 0 or wait_cnt == MAX_WAIT). A DMA grant with dma_lock moves the machine to DMA_LOCK.
  - DMA_LOCK: DMA granted while dma_req && dma_lock && lock_cnt < MAX_LOCK. It exits to CPU_PRI when dma_req or dma_lock drops. When lock_cnt reaches MAX_LOCK it goes to CPU_SLOT.
  - CPU_SLOT: one cycle. CPU granted if requesting; DMA is not granted. Then returns to CPU_PRI.
- wait_cnt (4 bit):
  - Increments each cycle dma_req is high and dma_gnt is low; saturates at MAX_WAIT.
  - Clears on dma_gnt or when dma_req is low.
- lock_cnt: set to 1 on entry to DMA_LOCK, increments per DMA_LOCK grant, clears on exit.
- cpu_stall = (cpu_en != 0) && !cpu_granted.
- Return path:
  - Registers rd_owner and rd_pending are set when a granted access has wr == 0.
  - Next cycle, cpu_rdata = mem_rdata if owner is CPU. dma_rdata = mem_rdata and dma_rvalid = 1 if owner is DMA.
  - Writes produce no return.
- Ordering: accesses reach memory strictly in grant order. A same-address write/read pair from different requesters is not reordered.
- CPU write strobes with cpu_wr bits outside cpu_en are passed unchanged (CPU guarantees subset).

## Timing
- Reset values:
  - Registers: state = CPU_PRI, wait_cnt = 0, lock_cnt = 0, rd_pending = 0.
  - Outputs: dma_rvalid = 0, dma_gnt = 0, cpu_stall = 0, mem_en = 0, mem_wr = 0, cpu_rdata and dma_rdata = 0 while no return is pending.
- Grant latency is 0 cycles (same cycle as request). Read data latency is 1 cycle after grant.
- Back-to-back accesses are sustained every cycle, one per cycle total.
- Reset mid-operation: a pending read return is discarded; dma_rvalid stays 0 the following cycle even if mem_rdata changes.
- Worst-case DMA wait without lock is MAX_WAIT cycles. Worst-case CPU stall under lock is MAX_LOCK cycles.
- Simultaneous force-grant (wait_cnt == MAX_WAIT) and cpu_en != 0: DMA wins and CPU stalls one cycle.

## Configuration
- DMEM_ARB_STARVE_EN:
  - Defined: wait_cnt, the MAX_WAIT force-grant and CPU_SLOT are compiled in.
  - Undefined: strict CPU priority. No wait_cnt exists. DMA_LOCK exits only on dma_req/dma_lock drop (MAX_LOCK ignored), and DMA may starve indefinitely.

## Test plan
- Idle CPU, DMA read addr 0x40, memory word 0xDEADBEEF -> dma_gnt=1, mem_en=F, mem_wr=0 that cycle; next cycle dma_rvalid=1, dma_rdata=0xDEADBEEF, cpu_stall=0.
- CPU read every cycle, dma_req held, MAX_WAIT=4, starvation macro on -> DMA granted on 5th cycle; cpu_stall=1 exactly that cycle; wait_cnt back to 0.
- Same as above, macro off -> dma_gnt never asserts over 100 cycles; cpu_stall stays 0.
- dma_lock held, CPU requesting, MAX_LOCK=8 -> 8 consecutive dma_gnt, then 1 CPU grant (CPU_SLOT), then DMA resumes; cpu_stall high 8 of every 9 cycles.
- CPU write 0x12345678 with cpu_wr=4'b0011 to 0x80 same cycle as a DMA read of 0x80 (CPU wins) -> next cycle DMA read returns low halfword 0x5678 merged; no rvalid for the write.
- Assert rst the cycle after a granted DMA read -> dma_rvalid=0, all outputs at reset values, state CPU_PRI after release.
